// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the IF-stage control and pc_unit.
// Latency: n/a (wires only). Backpressure: stall_i holds the PC; there is no ready/credit path.
// Requests (master -> slave): stall_i, br_valid_i/br_target_i, exc_i/exc_epc_i, eret_i.
// Responses (slave -> master): pc_o, npc_o, epc_o, in_handler_o, redirect_pend_o, adel_o.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall_i;
  logic             br_valid_i;
  logic [WIDTH-1:0] br_target_i;
  logic             exc_i;
  logic [WIDTH-1:0] exc_epc_i;
  logic             eret_i;

  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] npc_o;
  logic [WIDTH-1:0] epc_o;
  logic             in_handler_o;
  logic             redirect_pend_o;
  logic             adel_o;

  // Pipeline control side: issues requests, observes the fetch PC.
  modport master (
    output stall_i, br_valid_i, br_target_i, exc_i, exc_epc_i, eret_i,
    input  pc_o, npc_o, epc_o, in_handler_o, redirect_pend_o, adel_o
  );

  // pc_unit side.
  modport slave (
    input  stall_i, br_valid_i, br_target_i, exc_i, exc_epc_i, eret_i,
    output pc_o, npc_o, epc_o, in_handler_o, redirect_pend_o, adel_o
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with stall, buffered redirect, exception entry and eret.
// Latency: every request lands on the next rising edge; npc_o/adel_o are combinational from pc_o.
// Backpressure: stall_i holds pc; a redirect arriving while stalled is buffered until release.
//
// Ports: clk (rising edge), reset (synchronous, active-low), bus (pc_unit_if.slave).
// Optional macro PC_ADEL_EN: when defined, adel_o flags a misaligned or out-of-text fetch
// address; when undefined, adel_o is tied low and TEXT_LO/TEXT_HI are unused.
module pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] TEXT_LO  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TEXT_HI  = WIDTH'(32'h0000_6FFC)
) (
  input logic         clk,
  input logic         reset,
  pc_unit_if.slave    bus
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } mode_t;

  mode_t            state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0] epc, epc_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [WIDTH-1:0] pend_target, pend_target_nxt;
  logic [WIDTH-1:0] pc_plus4;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_plus4 = pc + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      epc         <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      epc         <= epc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // Priority chain: exception entry, eret, stall, fresh redirect, buffered redirect, +4.
  // Exception and eret ignore stall; an exception while already in the handler (or an
  // eret outside it) is dropped and the cycle continues down the chain.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc_plus4;
    epc_nxt         = epc;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;

    if (bus.exc_i && state == RUN) begin
      state_nxt      = HANDLER;
      pc_nxt         = EXC_PC;
      epc_nxt        = bus.exc_epc_i;
      pend_valid_nxt = 1'b0;
    end else if (bus.eret_i && state == HANDLER) begin
      state_nxt      = RUN;
      pc_nxt         = epc;
      pend_valid_nxt = 1'b0;
    end else if (bus.stall_i) begin
      pc_nxt = pc;
      // Newest redirect seen during the stall wins.
      if (bus.br_valid_i) begin
        pend_valid_nxt  = 1'b1;
        pend_target_nxt = bus.br_target_i;
      end
    end else if (bus.br_valid_i) begin
      pc_nxt         = bus.br_target_i;
      pend_valid_nxt = 1'b0;
    end else if (pend_valid) begin
      pc_nxt         = pend_target;
      pend_valid_nxt = 1'b0;
    end
  end

  assign bus.pc_o            = pc;
  assign bus.npc_o           = pc_plus4;
  assign bus.epc_o           = epc;
  assign bus.in_handler_o    = (state == HANDLER);
  assign bus.redirect_pend_o = pend_valid;

`ifdef PC_ADEL_EN
  assign bus.adel_o = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
`else
  logic unused_text_bounds;
  assign unused_text_bounds = ^{TEXT_LO, TEXT_HI};
  assign bus.adel_o         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios followed by randomized traffic against a behavioural model.
// Latency: model advances one step per rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: stall_i is driven randomly; no other flow control exists.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(16)) bus16 ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_unit #(
    .WIDTH    (16),
    .RESET_PC (16'hFFF8),
    .EXC_PC   (16'h4180),
    .TEXT_LO  (16'h3000),
    .TEXT_HI  (16'h6FFC)
  ) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

`ifdef PC_ADEL_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state, updated from the architectural rules only.
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_inh, m_pv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_adel(input logic [31:0] pc);
    if (!ADEL_ON) return 1'b0;
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction

  task automatic model_step(input logic rst, st, br, input logic [31:0] tgt,
                            input logic ex, input logic [31:0] ep, input logic er);
    if (!rst) begin
      m_pc = 32'h3000; m_epc = 0; m_inh = 0; m_pv = 0; m_pt = 0;
    end else if (ex && !m_inh) begin
      m_pc = 32'h4180; m_epc = ep; m_inh = 1; m_pv = 0;
    end else if (er && m_inh) begin
      m_pc = m_epc; m_inh = 0; m_pv = 0;
    end else if (st) begin
      if (br) begin m_pv = 1; m_pt = tgt; end
    end else if (br) begin
      m_pc = tgt; m_pv = 0;
    end else if (m_pv) begin
      m_pc = m_pt; m_pv = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("pc",      bus.pc_o,  m_pc);
    chk("npc",     bus.npc_o, m_pc + 32'd4);
    chk("epc",     bus.epc_o, m_epc);
    chk("in_hdl",  {31'b0, bus.in_handler_o},    {31'b0, m_inh});
    chk("pend",    {31'b0, bus.redirect_pend_o}, {31'b0, m_pv});
    chk("adel",    {31'b0, bus.adel_o},          {31'b0, exp_adel(m_pc)});
  endtask

  // Drive one cycle of inputs (just after an edge), clock it, then compare.
  task automatic step(input logic rst, st, br, input logic [31:0] tgt,
                      input logic ex, input logic [31:0] ep, input logic er);
    reset           = rst;
    bus.stall_i     = st;
    bus.br_valid_i  = br;
    bus.br_target_i = tgt;
    bus.exc_i       = ex;
    bus.exc_epc_i   = ep;
    bus.eret_i      = er;
    model_step(rst, st, br, tgt, ex, ep, er);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.stall_i = 0; bus.br_valid_i = 0; bus.br_target_i = 0;
    bus.exc_i = 0; bus.exc_epc_i = 0; bus.eret_i = 0;
    bus16.stall_i = 0; bus16.br_valid_i = 0; bus16.br_target_i = 0;
    bus16.exc_i = 0; bus16.exc_epc_i = 0; bus16.eret_i = 0;
    m_pc = 0; m_epc = 0; m_inh = 0; m_pv = 0; m_pt = 0;

    // Reset for two cycles, then release and free-run.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    chk("rst_pc",   bus.pc_o, 32'h3000);
    chk("rst_npc",  bus.npc_o, 32'h3004);
    chk("rst_epc",  bus.epc_o, 32'h0);
    chk("rst_inh",  {31'b0, bus.in_handler_o}, 32'h0);
    chk("rst_pend", {31'b0, bus.redirect_pend_o}, 32'h0);
    chk("rst_adel", {31'b0, bus.adel_o}, 32'h0);
    chk("w16_0",    {16'b0, bus16.pc_o}, 32'hFFF8);
    idle();
    chk("run_3004", bus.pc_o, 32'h3004);
    chk("w16_1",    {16'b0, bus16.pc_o}, 32'hFFFC);
    idle();
    chk("run_3008", bus.pc_o, 32'h3008);
    chk("w16_wrap", {16'b0, bus16.pc_o}, 32'h0000);

    // Redirect buffered across a 3-cycle stall.
    step(1, 1, 1, 32'h3100, 0, 0, 0);
    chk("stall_hold", bus.pc_o, 32'h3008);
    chk("stall_pend", {31'b0, bus.redirect_pend_o}, 32'h1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("stall_hold3", bus.pc_o, 32'h3008);
    idle();
    chk("pend_taken", bus.pc_o, 32'h3100);
    idle();
    chk("pend_next", bus.pc_o, 32'h3104);

    // Newer pending overwrites older; fresh redirect on release beats both.
    step(1, 1, 1, 32'h3100, 0, 0, 0);
    step(1, 1, 1, 32'h3200, 0, 0, 0);
    step(1, 0, 1, 32'h3300, 0, 0, 0);
    chk("fresh_wins", bus.pc_o, 32'h3300);
    chk("fresh_clr",  {31'b0, bus.redirect_pend_o}, 32'h0);

    // Exception under stall, ignored nested exception, eret.
    step(1, 1, 0, 0, 1, 32'h3010, 0);
    chk("exc_pc",  bus.pc_o, 32'h4180);
    chk("exc_epc", bus.epc_o, 32'h3010);
    chk("exc_inh", {31'b0, bus.in_handler_o}, 32'h1);
    step(1, 0, 0, 0, 1, 32'h4184, 0);
    chk("nest_epc", bus.epc_o, 32'h3010);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("eret_pc",  bus.pc_o, 32'h3010);
    chk("eret_inh", {31'b0, bus.in_handler_o}, 32'h0);

    // Fetch-address error flag.
    step(1, 0, 1, 32'h3002, 0, 0, 0);
    chk("adel_misalign", {31'b0, bus.adel_o}, {31'b0, ADEL_ON});
    step(1, 0, 1, 32'h7000, 0, 0, 0);
    chk("adel_high", {31'b0, bus.adel_o}, {31'b0, ADEL_ON});
    step(1, 0, 1, 32'h3004, 0, 0, 0);
    chk("adel_ok", {31'b0, bus.adel_o}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_st, r_br, r_ex, r_er;
      logic [31:0] r_tgt, r_ep;
      r_rst = ($urandom_range(0, 99) != 0);
      r_st  = ($urandom_range(0, 99) < 30);
      r_br  = ($urandom_range(0, 99) < 20);
      r_ex  = ($urandom_range(0, 99) < 5);
      r_er  = ($urandom_range(0, 99) < (m_inh ? 20 : 5));
      if ($urandom_range(0, 9) == 0)
        r_tgt = $urandom;
      else
        r_tgt = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      r_ep = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      step(r_rst, r_st, r_br, r_tgt, r_ex, r_ep, r_er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
